// File: rtl/tiny_decryption_algorithm_if.sv
// Ciphertext/key request and plaintext response bundle for the TEA decryptor.
// The master drives a ciphertext block and key; the slave returns the plaintext.
interface tiny_decryption_algorithm_if;
    logic         key_valid;
    logic         ctxt_valid;
    logic [63:0]  ctxt_blk;
    logic [127:0] key;
    logic [63:0]  ptxt_blk;
    logic         ptxt_ready;

    modport master (
        output key_valid,
        output ctxt_valid,
        output ctxt_blk,
        output key,
        input  ptxt_blk,
        input  ptxt_ready
    );

    modport slave (
        input  key_valid,
        input  ctxt_valid,
        input  ctxt_blk,
        input  key,
        output ptxt_blk,
        output ptxt_ready
    );
endinterface

// File: rtl/tiny_decryption_algorithm.sv
// Iterative TEA block decryptor: one full TEA cycle (both half-updates) per clock.
// Result is held in DONE until the next start or reset.
module tiny_decryption_algorithm #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic                              clk,
    input  logic                              rst_n,
    tiny_decryption_algorithm_if.slave        bus
);

    localparam int          CW       = $clog2(ROUNDS) + 1;
    localparam logic [31:0] SUM_INIT = 32'(DELTA * ROUNDS);
    localparam logic [CW-1:0] LAST   = CW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q,      state_d;
    logic [31:0]   v0_q,         v0_d;
    logic [31:0]   v1_q,         v1_d;
    logic [127:0]  key_q,        key_d;
    logic [31:0]   sum_q,        sum_d;
    logic [CW-1:0] count_q,      count_d;
    logic [63:0]   ptxt_blk_q,   ptxt_blk_d;
    logic          ptxt_ready_q, ptxt_ready_d;

    logic          start;
    logic [31:0]   v1_round;
    logic [31:0]   v0_round;

    // TEA mixing term shared by both half-updates.
    function automatic logic [31:0] mix(
        input logic [31:0] v,
        input logic [31:0] sum,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
    endfunction

    assign start = bus.ctxt_valid && bus.key_valid;

    // v0 is undone using the freshly recovered v1, mirroring the encryptor's order.
    assign v1_round = v1_q - mix(v0_q,     sum_q, key_q[63:32],  key_q[31:0]);
    assign v0_round = v0_q - mix(v1_round, sum_q, key_q[127:96], key_q[95:64]);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        v0_d         = v0_q;
        v1_d         = v1_q;
        key_d        = key_q;
        sum_d        = sum_q;
        count_d      = count_q;
        ptxt_blk_d   = ptxt_blk_q;
        ptxt_ready_d = ptxt_ready_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    v0_d         = bus.ctxt_blk[63:32];
                    v1_d         = bus.ctxt_blk[31:0];
                    key_d        = bus.key;
                    sum_d        = SUM_INIT;
                    count_d      = '0;
                    ptxt_ready_d = 1'b0;
                    state_d      = RUN;
                end
            end

            RUN: begin
                v0_d    = v0_round;
                v1_d    = v1_round;
                sum_d   = sum_q - DELTA;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    ptxt_blk_d   = {v0_round, v1_round};
                    ptxt_ready_d = 1'b1;
                    state_d      = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            v0_q         <= '0;
            v1_q         <= '0;
            key_q        <= '0;
            sum_q        <= '0;
            count_q      <= '0;
            ptxt_blk_q   <= '0;
            ptxt_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values, matching the hardware.
            state_q      <= state_d;
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            key_q        <= key_d;
            sum_q        <= sum_d;
            count_q      <= count_d;
            ptxt_blk_q   <= ptxt_blk_d;
            ptxt_ready_q <= ptxt_ready_d;
        end
    end

    assign bus.ptxt_blk   = ptxt_blk_q;
    assign bus.ptxt_ready = ptxt_ready_q;

endmodule
